display_sel_ctrl: RTL and testbench
===================================

// Module: display_sel_ctrl
// PURPOSE
//   Producer of the 3-bit register-select code consumed by the MU0 display-label decoder.
//   - Two raw push-buttons step the selection forward or back through codes 0..7:
//     A, di, do, Pc, Ir, Ac, d, A?
//   - An optional auto-scan mode cycles the selection at a fixed rate.
//   - Sits between the board buttons and the label/value display path.
// PARAMETERS
//   DEBOUNCE_CYCLES  50000  Clk cycles a synchronised button level must hold before it is accepted (>=2)
//   AUTO_PERIOD      1000000 Clk cycles between auto-scan steps (>=2)
//   SEL_W            3      Width of sel; the code wraps modulo 2**SEL_W
// PORTS
//   Clk         input   1      System clock; all state is rising-edge
//   Reset       input   1      Asynchronous, active-high reset
//   btn_next    input   1      Raw, asynchronous, bouncy "next" button (1 = pressed)
//   btn_prev    input   1      Raw, asynchronous, bouncy "previous" button (1 = pressed)
//   auto_en     input   1      Level; 1 = auto-scan enabled (see CONFIGURATION)
//   sel         output  SEL_W  Current register-select code
//   sel_change  output  1      One-cycle pulse in the cycle after sel takes a new value
// BEHAVIOUR
//   Reset:
//     - sel = 0, sel_change = 0.
//     - Debouncers go to RELEASED and their counters clear; the auto timer clears.
//     - Reset applies immediately mid-press or mid-count; a button held through reset
//       release generates no step until it is released and pressed again.
//   Input path: each button passes through a 2-flop synchroniser, then its own debouncer.
//   Debouncer FSM: RELEASED -> PRESS_WAIT -> PRESSED -> RELEASE_WAIT
//     RELEASED:
//       - sync=1 -> PRESS_WAIT, counter cleared.
//     PRESS_WAIT:
//       - sync=0 -> RELEASED.
//       - sync=1 -> counter increments.
//       - Counter reaching DEBOUNCE_CYCLES-1 with sync=1 -> PRESSED; emits a one-cycle
//         press pulse on entry.
//     PRESSED:
//       - sync=0 -> RELEASE_WAIT, counter cleared.
//     RELEASE_WAIT:
//       - sync=1 -> PRESSED, with no new pulse.
//       - Counter reaching DEBOUNCE_CYCLES-1 with sync=0 -> RELEASED.
//   Latency:
//     - A clean press produces its pulse 2 + DEBOUNCE_CYCLES cycles after the raw edge.
//     - sel updates on the cycle of the pulse; sel_change asserts the following cycle.
//   Step rules, evaluated each cycle with inc = next pulse and dec = prev pulse:
//     - inc & !dec -> sel + 1; 7 wraps to 0.
//     - dec & !inc -> sel - 1; 0 wraps to 7.
//     - inc & dec  -> no change and no sel_change.
//     - A held button produces exactly one step; there is no auto-repeat.
//   Auto-scan:
//     - While auto_en=1, the timer counts 0..AUTO_PERIOD-1. On its terminal count it
//       wraps to 0 and emits a tick, which acts as inc.
//     - Any button pulse in the same cycle as a tick takes priority: the tick is dropped
//       and the timer restarts from 0.
//     - Any button pulse while auto_en=1 restarts the timer.
//     - auto_en=0 clears the timer and holds it at 0.
//   sel_change asserts only when sel actually changed value.
// CONFIGURATION
//   DISPLAY_SEL_AUTO_EN:
//     - Defined: the auto-scan timer and auto_en behave as above.
//     - Undefined: the timer is not built, auto_en is ignored (port retained, unused),
//       and sel changes only on button pulses.
// STRUCTURE
//   Shared package / header:
//     - Debouncer state encoding: DB_RELEASED=2'd0, DB_PRESS_WAIT=2'd1, DB_PRESSED=2'd2,
//       DB_RELEASE_WAIT=2'd3.
//     - SEL code constants SEL_A=0 ... SEL_AQ=7, shared with the label decoder.
//   Sub-module btn_debounce (parameter DEBOUNCE_CYCLES):
//     - Contains the synchroniser, FSM and counter; outputs a press pulse.
//     - Instantiated twice.
//   The top level holds the sel register, step arbitration and the auto timer.
// TESTING (bench uses DEBOUNCE_CYCLES=4, AUTO_PERIOD=8, DISPLAY_SEL_AUTO_EN defined unless stated)
//   1 Reset then hold btn_next=1 for 20 cycles -> sel=1 exactly once, 6 cycles after the
//     edge; sel_change high for exactly 1 cycle.
//   2 btn_next bouncing 1,0,1,0 at 1-cycle intervals, then steady 1 -> one step only;
//     pulses shorter than 4 cycles give no step.
//   3 sel=7, press next -> sel=0. Then press prev -> sel=7 (wrap both ways).
//   4 Press both buttons with identical timing -> sel unchanged, sel_change never asserted.
//   5 auto_en=1 from sel=0 for 40 cycles -> sel steps 1,2,3,4,5 every 8 cycles. A next
//     press landing on a tick cycle -> a single step, with the next tick 8 cycles later.
//   6 Assert Reset mid PRESS_WAIT with sel=5 -> sel=0 immediately. Button held across
//     release -> no step; the next full press -> sel=1. Rebuild with DISPLAY_SEL_AUTO_EN
//     undefined and auto_en=1 -> sel constant.

Source files
------------

// File: rtl/display_sel_ctrl_pkg.sv
// Shared definitions for the MU0 display register-select path:
// debouncer state encoding and the select codes understood by the label decoder.
package display_sel_ctrl_pkg;

    typedef enum logic [1:0] {
        DB_RELEASED     = 2'd0,
        DB_PRESS_WAIT   = 2'd1,
        DB_PRESSED      = 2'd2,
        DB_RELEASE_WAIT = 2'd3
    } db_state_t;

    localparam logic [2:0] SEL_A  = 3'd0;
    localparam logic [2:0] SEL_DI = 3'd1;
    localparam logic [2:0] SEL_DO = 3'd2;
    localparam logic [2:0] SEL_PC = 3'd3;
    localparam logic [2:0] SEL_IR = 3'd4;
    localparam logic [2:0] SEL_AC = 3'd5;
    localparam logic [2:0] SEL_D  = 3'd6;
    localparam logic [2:0] SEL_AQ = 3'd7;

endpackage

// File: rtl/display_sel_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchroniser, debounce FSM and hold counter for one raw
// push-button. Emits a one-cycle press pulse when a press is accepted.
module btn_debounce
    import display_sel_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int unsigned   CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_PRE  = CW'(DEBOUNCE_CYCLES - 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic          armed;
    db_state_t     state;
    db_state_t     state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;

    // Synchroniser resets to "pressed" so a button held through reset looks
    // already down; together with armed this suppresses a step until it is let go.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
        end else begin
            meta <= btn;
            sync <= meta;
        end
    end

    // Arm once a released level has been seen since reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed <= 1'b0;
        end else if (!sync) begin
            armed <= 1'b1;
        end
    end

    // Debounce state and hold counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DB_RELEASED;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state; the press pulse is raised in the cycle whose edge makes the
    // counter reach DEBOUNCE_CYCLES-1, so the step lands on that same edge.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        press    = 1'b0;
        case (state)
            DB_RELEASED: begin
                if (sync && armed) begin
                    state_nx = DB_PRESS_WAIT;
                    cnt_nx   = '0;
                end
            end
            DB_PRESS_WAIT: begin
                if (!sync) begin
                    state_nx = DB_RELEASED;
                end else if (cnt == CNT_PRE) begin
                    state_nx = DB_PRESSED;
                    cnt_nx   = CNT_LAST;
                    press    = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DB_PRESSED: begin
                if (!sync) begin
                    state_nx = DB_RELEASE_WAIT;
                    cnt_nx   = '0;
                end
            end
            DB_RELEASE_WAIT: begin
                if (sync) begin
                    state_nx = DB_PRESSED;
                end else if (cnt == CNT_PRE) begin
                    state_nx = DB_RELEASED;
                    cnt_nx   = CNT_LAST;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = DB_RELEASED;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: rtl/display_sel_ctrl.sv
// display_sel_ctrl: register-select code for the MU0 display label decoder.
// Two debounced buttons step sel forward/back (mod 2**SEL_W).
// Optional auto-scan is built only when DISPLAY_SEL_AUTO_EN is defined.
module display_sel_ctrl
    import display_sel_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned AUTO_PERIOD     = 1000000,
    parameter int unsigned SEL_W           = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             btn_next,
    input  logic             btn_prev,
    input  logic             auto_en,
    output logic [SEL_W-1:0] sel,
    output logic             sel_change
);

    logic             next_p;
    logic             prev_p;
    logic             tick;
    logic             inc;
    logic             dec;
    logic [SEL_W-1:0] sel_nx;
    logic [SEL_W-1:0] sel_last;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk   (Clk),
        .rst   (Reset),
        .btn   (btn_next),
        .press (next_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
        .clk   (Clk),
        .rst   (Reset),
        .btn   (btn_prev),
        .press (prev_p)
    );

`ifdef DISPLAY_SEL_AUTO_EN
    localparam int unsigned   TW     = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(AUTO_PERIOD - 1);

    logic [TW-1:0] timer;
    logic          tc;

    assign tc   = auto_en && (timer == T_LAST);
    assign tick = tc && !(next_p || prev_p);

    // Auto-scan timer: held at 0 when disabled, restarted by any button pulse.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            timer <= '0;
        end else if (!auto_en || next_p || prev_p || tc) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end
`else
    logic unused_auto_en;

    assign unused_auto_en = auto_en;
    assign tick           = 1'b0;
`endif

    // Step arbitration: simultaneous up and down cancel.
    always_comb begin
        inc    = next_p || tick;
        dec    = prev_p;
        sel_nx = sel;
        if (inc && !dec) begin
            sel_nx = sel + 1'b1;
        end else if (dec && !inc) begin
            sel_nx = sel - 1'b1;
        end
    end

    // Select register; sel_change flags a new value one cycle after it appears.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sel        <= SEL_W'(SEL_A);
            sel_last   <= SEL_W'(SEL_A);
            sel_change <= 1'b0;
        end else begin
            sel        <= sel_nx;
            sel_last   <= sel;
            sel_change <= (sel != sel_last);
        end
    end

endmodule

// File: tb/tb_display_sel_ctrl.sv
// Bench for display_sel_ctrl with DEBOUNCE_CYCLES=4, AUTO_PERIOD=8.
// Auto-scan expectations follow whether DISPLAY_SEL_AUTO_EN is defined in this build.
module tb_display_sel_ctrl;

    localparam int unsigned D = 4;
    localparam int unsigned P = 8;
`ifdef DISPLAY_SEL_AUTO_EN
    localparam bit AB = 1'b1;
`else
    localparam bit AB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic       auto_en = 1'b0;
    logic [2:0] sel;
    logic       sel_change;

    int checks = 0;
    int errors = 0;

    display_sel_ctrl #(.DEBOUNCE_CYCLES(D), .AUTO_PERIOD(P), .SEL_W(3)) dut (
        .Clk        (clk),
        .Reset      (rst),
        .btn_next   (btn_next),
        .btn_prev   (btn_prev),
        .auto_en    (auto_en),
        .sel        (sel),
        .sel_change (sel_change)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a press (or release) is accepted once the synchronised
    // level has been steady for D consecutive samples; steps are mod-8 arithmetic.
    bit m_s1[2];
    bit m_s2[2];
    bit m_runval[2];
    int m_run[2];
    bit m_level[2];
    bit m_armed[2];
    bit m_pulse[2];
    int m_sel;
    int m_el;
    bit m_chg;
    bit m_pend;

    always @(posedge clk) begin
        bit v;
        bit r;
        bit tick;
        int delta;
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 1'b1;  m_s2[b] = 1'b1;
                m_runval[b] = 1'b1; m_run[b] = 0;
                m_level[b] = 1'b0; m_armed[b] = 1'b0; m_pulse[b] = 1'b0;
            end
            m_sel = 0; m_el = 0; m_chg = 1'b0; m_pend = 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                r = (b == 0) ? btn_next : btn_prev;
                v = m_s2[b];
                m_s2[b] = m_s1[b];
                m_s1[b] = r;
                if (!v) m_armed[b] = 1'b1;
                if (v == m_runval[b]) m_run[b]++;
                else begin m_runval[b] = v; m_run[b] = 1; end
                m_pulse[b] = 1'b0;
                if (m_armed[b] && m_run[b] >= int'(D) && m_level[b] != v) begin
                    m_level[b] = v;
                    m_pulse[b] = v;
                end
            end
            tick = 1'b0;
`ifdef DISPLAY_SEL_AUTO_EN
            if (!auto_en || m_pulse[0] || m_pulse[1]) m_el = 0;
            else if (m_el + 1 == int'(P)) begin tick = 1'b1; m_el = 0; end
            else m_el++;
`endif
            delta = ((m_pulse[0] || tick) ? 1 : 0) - (m_pulse[1] ? 1 : 0);
            m_chg  = m_pend;
            m_pend = (delta != 0);
            m_sel  = (m_sel + 8 + delta) % 8;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        chk("sel_vs_model", 32'(sel), 32'(m_sel));
        chk("chg_vs_model", 32'(sel_change), 32'(m_chg));
    end

    // b: 0 next, 1 prev, 2 both
    task automatic press(input int b, input int hold);
        @(negedge clk);
        if (b != 1) btn_next = 1'b1;
        if (b != 0) btn_prev = 1'b1;
        repeat (hold) @(negedge clk);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int first;
        int nchg;
        int nz;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sel", 32'(sel), 0);
        chk("reset_chg", 32'(sel_change), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: single held press, latency 6, one sel_change
        btn_next = 1'b1;
        first = -1; nchg = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (sel != 3'd0 && first < 0) first = i;
            if (sel_change) nchg++;
        end
        chk("t1_latency", 32'(first), 6);
        chk("t1_sel", 32'(sel), 1);
        chk("t1_chg_count", 32'(nchg), 1);
        @(negedge clk);
        btn_next = 1'b0;
        repeat (10) @(negedge clk);

        // 2: bounce then steady press -> one step; short pulses ignored
        btn_next = 1'b1; @(negedge clk);
        btn_next = 1'b0; @(negedge clk);
        btn_next = 1'b1; @(negedge clk);
        btn_next = 1'b0; @(negedge clk);
        btn_next = 1'b1;
        repeat (15) @(negedge clk);
        btn_next = 1'b0;
        repeat (10) @(negedge clk);
        chk("t2_bounce_sel", 32'(sel), 2);
        press(1, 3);
        press(0, 3);
        chk("t2_short_sel", 32'(sel), 2);

        // 3: wrap both ways
        repeat (5) press(0, 8);
        chk("t3_sel7", 32'(sel), 7);
        press(0, 8);
        chk("t3_wrap_up", 32'(sel), 0);
        press(1, 8);
        chk("t3_wrap_down", 32'(sel), 7);

        // 4: both buttons together -> no change
        @(negedge clk);
        btn_next = 1'b1; btn_prev = 1'b1;
        nchg = 0;
        repeat (20) begin @(posedge clk); #1; if (sel_change) nchg++; end
        @(negedge clk);
        btn_next = 1'b0; btn_prev = 1'b0;
        repeat (12) begin @(posedge clk); #1; if (sel_change) nchg++; end
        chk("t4_both_sel", 32'(sel), 7);
        chk("t4_both_chg", 32'(nchg), 0);
        press(0, 8);
        chk("t4_back_to_0", 32'(sel), 0);

        // 5: auto-scan, then a press landing on a tick
        auto_en = 1'b1;
        repeat (8) @(posedge clk); #1;
        chk("t5_first_tick", 32'(sel), AB ? 1 : 0);
        repeat (32) @(posedge clk); #1;
        chk("t5_after_40", 32'(sel), AB ? 5 : 0);
        repeat (3) @(negedge clk);
        btn_next = 1'b1;
        repeat (5) @(posedge clk); #1;
        chk("t5_before_hit", 32'(sel), AB ? 5 : 0);
        @(posedge clk); #1;
        chk("t5_on_hit", 32'(sel), AB ? 6 : 1);
        repeat (7) @(posedge clk); #1;
        chk("t5_hold_after_hit", 32'(sel), AB ? 6 : 1);
        @(posedge clk); #1;
        chk("t5_next_tick", 32'(sel), AB ? 7 : 1);
        @(negedge clk);
        btn_next = 1'b0;
        auto_en = 1'b0;
        repeat (12) @(negedge clk);

        // 6: reset mid-press, held across release
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        repeat (5) press(0, 8);
        chk("t6_sel5", 32'(sel), 5);
        @(negedge clk);
        btn_next = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_async_reset", 32'(sel), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nchg = 0; nz = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (sel_change) nchg++;
            if (sel != 3'd0) nz++;
        end
        chk("t6_held_no_step", 32'(nz), 0);
        chk("t6_held_no_chg", 32'(nchg), 0);
        @(negedge clk);
        btn_next = 1'b0;
        repeat (10) @(negedge clk);
        press(0, 8);
        chk("t6_next_press", 32'(sel), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
